// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing constants and TX state encoding.
// Used by fifo_uart_tx and uart_baud_gen (and a future RX stage).
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int DATA_BITS        = 8;
  localparam int STOP_BITS        = 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    REQ   = ST_REQ,
    LOAD  = ST_LOAD,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, one-cycle tick every CLKS_PER_BIT.
// Ports: clk, reset_n (async low), run (count enable), tick (out).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] r_cnt;

  assign tick = run && (r_cnt == LAST);

  // Held at zero while stopped so every bit period starts aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!run || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the byte FIFO, sends them 8N1 on tx.
// Ports: clk, reset_n, empty, read_valid, din[7:0] in;
//        rden, tx, busy, byte_done out.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       empty,
  input  logic       read_valid,
  input  logic [7:0] din,
  output logic       rden,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam logic [2:0] BIT_PRE_LAST = 3'(DATA_BITS - 2);

  tx_state_e  r_state;
  tx_state_e  w_next;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_bit_last;
  logic       w_run;
  logic       w_tick;

  assign w_run = (r_state == START) ||
                 (r_state == DATA)  ||
                 (r_state == STOP);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (w_run),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // r_bit_last flags the final data bit so STOP entry needs no compare
  // against the wrapping 3-bit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_bit_last <= 1'b0;
    end else if (r_state == LOAD) begin
      r_shift    <= din;
      r_bit_cnt  <= '0;
      r_bit_last <= 1'b0;
    end else if (r_state == DATA && w_tick) begin
      r_shift    <= {1'b0, r_shift[7:1]};
      r_bit_cnt  <= r_bit_cnt + 1'b1;
      r_bit_last <= (r_bit_cnt == BIT_PRE_LAST);
    end
  end

  // rden is decoded from REQ alone; REQ is only entered after a
  // non-empty flag, and a lost pop (read_valid=0) just retries.
  always_comb begin
    w_next    = r_state;
    rden      = 1'b0;
    tx        = 1'b1;
    busy      = 1'b0;
    byte_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!empty) w_next = REQ;
      end
      REQ: begin
        rden   = 1'b1;
        w_next = read_valid ? LOAD : IDLE;
      end
      LOAD: begin
        busy   = 1'b1;
        w_next = START;
      end
      START: begin
        busy = 1'b1;
        tx   = 1'b0;
        if (w_tick) w_next = DATA;
      end
      DATA: begin
        busy = 1'b1;
        tx   = r_shift[0];
        if (w_tick && r_bit_last) w_next = STOP;
      end
      STOP: begin
        busy      = 1'b1;
        byte_done = w_tick;
        if (w_tick) w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: FIFO model + UART frame monitor with byte scoreboard.
// Drives reset, single, back-to-back, collision and mid-frame reset cases.
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       empty;
  logic       read_valid;
  logic [7:0] din;
  logic       rden;
  logic       tx;
  logic       busy;
  logic       byte_done;

  logic       wren  = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] f_mem [8];
  logic [2:0] f_wp  = '0;
  logic [2:0] f_rp  = '0;
  logic [7:0] f_dout = '0;
  int         f_cnt = 0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb[$];
  int         start_q[$];

  int cyc          = 0;
  int rden_cnt     = 0;
  int rv_cnt       = 0;
  int rd_empty_cnt = 0;
  int done_cnt     = 0;
  int frame_cnt    = 0;

  logic       in_frame  = 1'b0;
  int         pos       = 0;
  logic [9:0] exp_frame = '1;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .empty     (empty),
    .read_valid(read_valid),
    .din       (din),
    .rden      (rden),
    .tx        (tx),
    .busy      (busy),
    .byte_done (byte_done)
  );

  always #5 clk = ~clk;

  // FIFO read port: a write in the same cycle drops the read.
  assign empty      = (f_cnt == 0);
  assign read_valid = rden && !empty && !wren;
  assign din        = f_dout;

  always @(posedge clk) begin
    if (wren) begin
      f_mem[f_wp] <= wdata;
      f_wp        <= f_wp + 3'd1;
    end
    if (read_valid) begin
      f_dout <= f_mem[f_rp];
      f_rp   <= f_rp + 3'd1;
    end
    f_cnt <= f_cnt + (wren ? 1 : 0) - (read_valid ? 1 : 0);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n) begin
      if (rden)          rden_cnt     <= rden_cnt + 1;
      if (read_valid)    rv_cnt       <= rv_cnt + 1;
      if (rden && empty) rd_empty_cnt <= rd_empty_cnt + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame monitor: a low on tx opens a frame; every cycle of it is
  // compared with the expected 10-bit frame of the oldest queued byte.
  always @(negedge clk) begin : mon
    logic [9:0] f;
    logic [7:0] b;
    int         p;
    f = exp_frame;
    p = pos;
    if (!reset_n) begin
      in_frame <= 1'b0;
    end else begin
      if (byte_done) done_cnt <= done_cnt + 1;
      if (!in_frame && !tx) begin
        p = 0;
        start_q.push_back(cyc);
        frame_cnt <= frame_cnt + 1;
        if (sb.size() == 0) begin
          check("spurious_frame", 32'd1, 32'd0);
          f = '1;
        end else begin
          b = sb.pop_front();
          f = {1'b1, b, 1'b0};
        end
      end
      if (in_frame || !tx) begin
        check("tx_bit", tx, f[p / CPB]);
        check("busy_in_frame", busy, 1);
        check("byte_done", byte_done, p == FRAME - 1);
        in_frame  <= (p != FRAME - 1);
        pos       <= p + 1;
        exp_frame <= f;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    wren  = 1'b1;
    wdata = b;
    sb.push_back(b);
    @(negedge clk);
    wren  = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      #1;
      if (!busy && !rden && !in_frame &&
          f_cnt == 0 && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int v0;
    int d0;
    int fc0;
    int n0;
    bit ok;

    // Reset held with a byte waiting in the FIFO.
    @(negedge clk);
    push(8'h3C);
    repeat (3) begin
      check("rst_tx", tx, 1);
      check("rst_rden", rden, 0);
      check("rst_busy", busy, 0);
      check("rst_done", byte_done, 0);
      @(negedge clk);
    end
    reset_n = 1'b1;
    #1;
    check("rden_at_release", rden, 0);
    @(negedge clk);
    check("rden_one_cycle", rden, 1);
    wait_idle(200);

    // Single byte 0xA5.
    r0  = rden_cnt;
    v0  = rv_cnt;
    d0  = done_cnt;
    fc0 = frame_cnt;
    push(8'hA5);
    wait_idle(200);
    check("a5_rden", rden_cnt - r0, 1);
    check("a5_reads", rv_cnt - v0, 1);
    check("a5_done", done_cnt - d0, 1);
    check("a5_frames", frame_cnt - fc0, 1);

    // Back-to-back 0x00, 0xFF.
    n0 = start_q.size();
    push(8'h00);
    push(8'hFF);
    wait_idle(300);
    check("b2b_frames", start_q.size() - n0, 2);
    if (start_q.size() >= n0 + 2)
      check("b2b_period", start_q[n0+1] - start_q[n0], FRAME + 3);
    check("b2b_fifo_empty", f_cnt, 0);
    check("b2b_busy", busy, 0);

    // Write collides with the read request.
    r0  = rden_cnt;
    v0  = rv_cnt;
    fc0 = frame_cnt;
    push(8'h5A);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rden) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("coll_req_seen", ok, 1);
    push(8'hC3);
    wait_idle(300);
    check("coll_rden", rden_cnt - r0, 3);
    check("coll_reads", rv_cnt - v0, 2);
    check("coll_frames", frame_cnt - fc0, 2);

    // Reset during data bit 3 of 0x96; 0x81 must follow cleanly.
    push(8'h96);
    push(8'h81);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!tx) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_start_seen", ok, 1);
    repeat (4 * CPB + 1) @(negedge clk);
    check("mid_pre_rst_tx", tx, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rden", rden, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    fc0 = frame_cnt;
    wait_idle(300);
    check("mid_frames", frame_cnt - fc0, 1);
    check("mid_fifo_empty", f_cnt, 0);

    check("rd_when_empty", rd_empty_cnt, 0);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
